single_rocket_mover: RTL and testbench

//  Per-rocket responder for the rockets launch controller. Accepts a launch (rising isActive + initial

---
 rtl/single_rocket_mover.sv | 133 +++++++++++++
 tb/tb_single_rocket_mover.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/single_rocket_mover.sv
// Per-rocket mover: launches on a rising isActive, steps Y once per frame in
// fixed point, and retires on collision (after an explosion) or on leaving the screen.
module single_rocket_mover #(
    parameter int FRAC_BITS      = 6,
    parameter int SCREEN_TOP     = 0,
    parameter int SCREEN_BOTTOM  = 479,
    parameter int ROCKET_HEIGHT  = 16,
    parameter int EXPLODE_FRAMES = 4
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               isActive,
    input  logic signed [8:0]  initialSpeed,
    input  logic signed [10:0] initialX,
    input  logic signed [10:0] initialY,
    input  logic               collision,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic               rocketVisible,
    output logic               exploding,
    output logic               busy,
    output logic               rocketDone,
    output logic               rocketHit
);
    localparam int YW = 11 + FRAC_BITS;
    localparam int CW = (EXPLODE_FRAMES < 2) ? 1 : $clog2(EXPLODE_FRAMES);
    localparam logic [CW-1:0] CNT_LAST = CW'(EXPLODE_FRAMES - 1);
    // Limits compared one bit wider than yFix so the sum cannot wrap.
    localparam logic signed [YW:0] LIM_TOP = (YW + 1)'(SCREEN_TOP - ROCKET_HEIGHT);
    localparam logic signed [YW:0] LIM_BOT = (YW + 1)'(SCREEN_BOTTOM);

    typedef enum logic [1:0] {IDLE, FLYING, EXPLODE} state_t;

    state_t                state_q, state_d;
    logic signed [10:0]    x_q, x_d;
    logic signed [YW-1:0]  yfix_q, yfix_d;
    logic signed [YW-1:0]  speed_q, speed_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  isactive_q, isactive_d;
    logic                  done_q, done_d;
    logic                  hit_q, hit_d;

    logic signed [YW:0]    yfix_n;
    logic signed [YW:0]    ypix_n;
    logic                  off_screen;
    logic                  launch;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= IDLE;
            x_q        <= '0;
            yfix_q     <= '0;
            speed_q    <= '0;
            cnt_q      <= '0;
            isactive_q <= 1'b1;
            done_q     <= 1'b0;
            hit_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            yfix_q     <= yfix_d;
            speed_q    <= speed_d;
            cnt_q      <= cnt_d;
            isactive_q <= isactive_d;
            done_q     <= done_d;
            hit_q      <= hit_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        yfix_d     = yfix_q;
        speed_d    = speed_q;
        cnt_d      = cnt_q;
        isactive_d = isActive;
        done_d     = 1'b0;
        hit_d      = 1'b0;

        yfix_n     = {yfix_q[YW-1], yfix_q} + {speed_q[YW-1], speed_q};
        ypix_n     = yfix_n >>> FRAC_BITS;
        off_screen = (ypix_n < LIM_TOP) || (ypix_n > LIM_BOT);
        launch     = isActive && !isactive_q;

        unique case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = FLYING;
                    x_d     = initialX;
                    yfix_d  = {initialY, {FRAC_BITS{1'b0}}};
                    speed_d = {{(YW - 9){initialSpeed[8]}}, initialSpeed};
                end
            end
            FLYING: begin
                // Collision freezes the position even on a frame tick.
                if (collision) begin
                    state_d = EXPLODE;
                    cnt_d   = '0;
                end else if (startOfFrame) begin
                    if (off_screen) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        yfix_d = yfix_n[YW-1:0];
                    end
                end
            end
            EXPLODE: begin
                if (startOfFrame) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        hit_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        topLeftX      = x_q;
        topLeftY      = yfix_q[YW-1:FRAC_BITS];
        rocketVisible = (state_q == FLYING);
        exploding     = (state_q == EXPLODE);
        busy          = (state_q != IDLE);
        rocketDone    = done_q;
        rocketHit     = hit_q;
    end
endmodule

// File: tb/tb_single_rocket_mover.sv
// Directed bench for single_rocket_mover; retire pulses are checked by a
// scoreboard monitor against expectations queued by the stimulus.
module tb_single_rocket_mover;
    logic               clk = 1'b0;
    logic               resetN;
    logic               startOfFrame;
    logic               isActive;
    logic signed [8:0]  initialSpeed;
    logic signed [10:0] initialX;
    logic signed [10:0] initialY;
    logic               collision;
    logic signed [10:0] topLeftX;
    logic signed [10:0] topLeftY;
    logic               rocketVisible;
    logic               exploding;
    logic               busy;
    logic               rocketDone;
    logic               rocketHit;

    typedef struct {
        logic hit;
        int   y;
    } done_t;

    done_t exp_q[$];
    int    n_total = 0;
    int    n_pass  = 0;

    single_rocket_mover dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .isActive(isActive),
        .initialSpeed(initialSpeed), .initialX(initialX), .initialY(initialY),
        .collision(collision), .topLeftX(topLeftX), .topLeftY(topLeftY),
        .rocketVisible(rocketVisible), .exploding(exploding), .busy(busy),
        .rocketDone(rocketDone), .rocketHit(rocketHit)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sof(input int n);
        repeat (n) begin
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
            tick();
        end
    endtask

    task automatic launch(input int x, input int y, input int spd);
        isActive = 1'b0;
        tick();
        initialX     = 11'(x);
        initialY     = 11'(y);
        initialSpeed = 9'(spd);
        isActive     = 1'b1;
        tick();
        isActive     = 1'b0;
    endtask

    // Scoreboard monitor: every retire pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (resetN && rocketDone) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL done_unexpected: got done hit=%0b y=%0d expected no done", rocketHit, topLeftY);
            end else begin
                done_t e;
                e = exp_q.pop_front();
                if (rocketHit == e.hit && int'(topLeftY) == e.y) n_pass++;
                else $display("FAIL done_pulse: got hit=%0b y=%0d expected hit=%0b y=%0d",
                              rocketHit, topLeftY, e.hit, e.y);
            end
        end
        if (!rocketDone && rocketHit) begin
            n_total++;
            $display("FAIL hit_without_done: got rocketHit=1 expected 0");
        end
    end

    initial begin
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        isActive     = 1'b0;
        initialSpeed = '0;
        initialX     = '0;
        initialY     = '0;
        collision    = 1'b0;
        #13;
        chk("reset_busy", busy, 0);
        chk("reset_y", topLeftY, 0);
        chk("reset_done", rocketDone, 0);
        #10 resetN = 1'b1;
        tick();

        // 1: integer-pixel upward motion
        launch(300, 400, -128);
        chk("t1_visible", rocketVisible, 1);
        chk("t1_y0", topLeftY, 400);
        sof(1);
        chk("t1_y1", topLeftY, 398);
        sof(9);
        chk("t1_y10", topLeftY, 380);
        chk("t1_x", topLeftX, 300);
        collision = 1'b1;
        tick();
        collision = 1'b0;
        chk("t1_exploding", exploding, 1);
        exp_q.push_back('{hit: 1'b1, y: 380});
        sof(4);
        chk("t1_retired", busy, 0);

        // 2: fractional speed accumulates below one pixel
        launch(50, 400, -96);
        sof(1);
        chk("t2_y1", topLeftY, 398);
        sof(1);
        chk("t2_y2", topLeftY, 397);
        collision = 1'b1;
        tick();
        collision = 1'b0;
        exp_q.push_back('{hit: 1'b1, y: 397});
        sof(4);

        // 3: exit through the top edge
        launch(20, 10, -128);
        sof(13);
        chk("t3_y13", topLeftY, -16);
        chk("t3_still_flying", rocketVisible, 1);
        exp_q.push_back('{hit: 1'b0, y: -16});
        sof(1);
        chk("t3_busy_after_exit", busy, 0);
        chk("t3_visible_after_exit", rocketVisible, 0);

        // 4: collision on a frame tick freezes position; retire and launch edge collide
        launch(100, 390, -128);
        collision    = 1'b1;
        startOfFrame = 1'b1;
        tick();
        collision    = 1'b0;
        startOfFrame = 1'b0;
        chk("t4_y_frozen", topLeftY, 390);
        chk("t4_exploding", exploding, 1);
        chk("t4_not_visible", rocketVisible, 0);
        sof(3);
        chk("t4_busy_before_last", busy, 1);
        exp_q.push_back('{hit: 1'b1, y: 390});
        startOfFrame = 1'b1;
        isActive     = 1'b1;
        tick();
        startOfFrame = 1'b0;
        chk("t4_retired", busy, 0);
        tick();
        chk("t4_edge_lost", busy, 0);
        chk("t4_y_hold", topLeftY, 390);
        isActive = 1'b0;

        // 5: second launch edge while flying is ignored; relaunch after done
        launch(200, 200, 64);
        sof(1);
        chk("t5_y1", topLeftY, 201);
        launch(7, 7, -200);
        chk("t5_x_kept", topLeftX, 200);
        sof(1);
        chk("t5_y2", topLeftY, 202);
        collision = 1'b1;
        tick();
        collision = 1'b0;
        exp_q.push_back('{hit: 1'b1, y: 202});
        sof(4);
        launch(111, 222, 0);
        chk("t5_relaunch", rocketVisible, 1);
        chk("t5_relaunch_x", topLeftX, 111);
        sof(3);
        chk("t5_hover", topLeftY, 222);
        collision = 1'b1;
        tick();
        collision = 1'b0;
        exp_q.push_back('{hit: 1'b1, y: 222});
        sof(4);

        // bottom edge: 478 + 2 = 480 exceeds the last row
        launch(5, 478, 128);
        exp_q.push_back('{hit: 1'b0, y: 478});
        sof(1);
        chk("bot_exit", busy, 0);

        // 6: asynchronous reset mid-flight; held isActive must not launch
        launch(60, 300, -64);
        sof(2);
        isActive = 1'b1;
        #2 resetN = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_visible", rocketVisible, 0);
        chk("t6_y", topLeftY, 0);
        chk("t6_x", topLeftX, 0);
        #10 resetN = 1'b1;
        tick();
        tick();
        chk("t6_no_launch", busy, 0);
        isActive = 1'b0;
        tick();
        isActive = 1'b1;
        tick();
        chk("t6_fresh_edge", rocketVisible, 1);

        repeat (4) tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
